// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register-bank slice.
//
// Purpose: default widths, the register-index and data typedefs, and the
// index of the hardwired-zero register. The bank and its multiply
// scoreboard import this package so they agree on what "register 0" means.
//
// Contents:
//   DEFAULT_NUM_REGS, DEFAULT_DATA_WIDTH, DEFAULT_REG_ID_WIDTH  default sizes
//   reg_id_t   register index at the default width
//   data_t     register value at the default width
//   ZERO_REG   index of the register that always reads as zero
package cpu_pkg;

  localparam int DEFAULT_NUM_REGS     = 32;
  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_REG_ID_WIDTH = 5;

  typedef logic [DEFAULT_REG_ID_WIDTH-1:0] reg_id_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0]   data_t;

  localparam reg_id_t ZERO_REG = '0;

endpackage : cpu_pkg

// File: rtl/cpu_mul_scoreboard.sv
// Pending-write scoreboard for in-flight multiplies.
//
// Purpose: remembers which architectural registers are waiting on a
// multiplier result so decode can stall on RAW/WAW hazards. Holds the busy
// vector, its population count and a sticky WAW error flag.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   mul_issue_i/_reg_i      a multiply enters the multiplier, and its target
//   write_enable_mul_i      a multiply completes this cycle
//   write_reg_mul_i         register the completing multiply writes
//   read_reg_a_i/_b_i       decode read indices to look up
//   busy_a_o/busy_b_o       looked-up register still awaits a multiply
//   mul_pending_o           number of busy registers (registered)
//   waw_error_o             sticky: multiply issued to an already-busy reg
module cpu_mul_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int REG_ID_WIDTH = DEFAULT_REG_ID_WIDTH,
  parameter int CNT_WIDTH    = $clog2(NUM_REGS) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mul_issue_i,
  input  logic [REG_ID_WIDTH-1:0] mul_issue_reg_i,
  input  logic                    write_enable_mul_i,
  input  logic [REG_ID_WIDTH-1:0] write_reg_mul_i,
  input  logic [REG_ID_WIDTH-1:0] read_reg_a_i,
  input  logic [REG_ID_WIDTH-1:0] read_reg_b_i,
  output logic                    busy_a_o,
  output logic                    busy_b_o,
  output logic [CNT_WIDTH-1:0]    mul_pending_o
  ,
  output logic                    waw_error_o
);

  localparam logic [REG_ID_WIDTH-1:0] ZERO_ID = REG_ID_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0]  busy_q, busy_d;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic                 waw_q, waw_d;

  logic setValid;
  logic clrValid;
  logic sameReg;
  logic incCount;
  logic decCount;

  // Next-state for the busy vector, its population count and the WAW flag.
  // The clear is applied before the set so that a completion and a fresh
  // issue to the same register leave the bit set (back-to-back multiplies).
  // The counter follows the population of the vector: it only moves when a
  // bit actually changes value, so redundant sets/clears do not disturb it.
  always_comb begin
    setValid = mul_issue_i && (mul_issue_reg_i != ZERO_ID);
    clrValid = write_enable_mul_i && (write_reg_mul_i != ZERO_ID);
    sameReg  = setValid && clrValid && (mul_issue_reg_i == write_reg_mul_i);

    incCount = setValid && !busy_q[mul_issue_reg_i];
    decCount = clrValid && busy_q[write_reg_mul_i] && !sameReg;

    busy_d = busy_q;
    if (clrValid) begin
      busy_d[write_reg_mul_i] = 1'b0;
    end
    if (setValid) begin
      busy_d[mul_issue_reg_i] = 1'b1;
    end

    pending_d = pending_q;
    if (incCount && !decCount) begin
      pending_d = pending_q + CNT_WIDTH'(1);
    end else if (decCount && !incCount) begin
      pending_d = pending_q - CNT_WIDTH'(1);
    end

    // A re-issue to a busy register is only legal when the previous result
    // is retiring in the very same cycle.
    waw_d = waw_q | (setValid && busy_q[mul_issue_reg_i] && !sameReg);
  end

  // Scoreboard state; reset throws away all in-flight bookkeeping along with
  // anything presented on the inputs in the reset cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      pending_q <= '0;
      waw_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      waw_q     <= waw_d;
    end
  end

  // Stall lookup for decode. A register whose multiply completes this cycle
  // is already visible through the bank's bypass, so it is not reported busy.
  // An issue in this cycle deliberately does not show up here.
  always_comb begin
    busy_a_o = (read_reg_a_i != ZERO_ID) && busy_q[read_reg_a_i] &&
               !(write_enable_mul_i && (write_reg_mul_i == read_reg_a_i));
    busy_b_o = (read_reg_b_i != ZERO_ID) && busy_q[read_reg_b_i] &&
               !(write_enable_mul_i && (write_reg_mul_i == read_reg_b_i));
  end

  assign mul_pending_o = pending_q;
  assign waw_error_o   = waw_q;

endmodule : cpu_mul_scoreboard

// File: rtl/cpu_bank_reg.sv
// Architectural register bank with two write ports and two bypassed reads.
//
// Purpose: write-side endpoint of writeback (ALU/load port plus the
// long-latency multiplier port) and the operand source for decode. Register
// 0 is hardwired to zero. A multiply scoreboard reports which registers are
// still waiting on a multiplier result.
//
// Ports:
//   clock, reset                     rising-edge clock, sync active-high reset
//   read_reg_a/b, read_data_a/b      combinational read ports with bypass
//   busy_a/b                         read index awaits an in-flight multiply
//   write_enable/_reg/_data          ALU/load write port
//   write_enable_mul/_reg_mul/_data_mul  multiplier write port
//   mul_issue, mul_issue_reg         a multiply is issued, and its destination
//   mul_pending                      number of busy registers (registered)
//   waw_error                        sticky multiply WAW violation flag
module cpu_bank_reg
  import cpu_pkg::*;
#(
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int REG_ID_WIDTH = DEFAULT_REG_ID_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic [REG_ID_WIDTH-1:0]   read_reg_a,
  input  logic [REG_ID_WIDTH-1:0]   read_reg_b,
  output logic [DATA_WIDTH-1:0]     read_data_a,
  output logic [DATA_WIDTH-1:0]     read_data_b,
  output logic                      busy_a,
  output logic                      busy_b,

  input  logic                      write_enable,
  input  logic [REG_ID_WIDTH-1:0]   write_reg,
  input  logic [DATA_WIDTH-1:0]     write_data,

  input  logic                      write_enable_mul,
  input  logic [REG_ID_WIDTH-1:0]   write_reg_mul,
  input  logic [DATA_WIDTH-1:0]     write_data_mul,

  input  logic                      mul_issue,
  input  logic [REG_ID_WIDTH-1:0]   mul_issue_reg,
  output logic [$clog2(NUM_REGS):0] mul_pending,
  output logic                      waw_error
);

  localparam logic [REG_ID_WIDTH-1:0] ZERO_ID = REG_ID_WIDTH'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  logic aluWrite;
  logic mulWrite;

  assign aluWrite = write_enable     && (write_reg     != ZERO_ID);
  assign mulWrite = write_enable_mul && (write_reg_mul != ZERO_ID);

  // Write arbitration. The ALU port is applied last so it overrides the
  // multiplier when both target the same register: the ALU result belongs
  // to the younger instruction. Writes to register 0 are dropped here, so
  // entry 0 of the array stays zero forever.
  always_comb begin
    regs_d = regs_q;
    if (mulWrite) begin
      regs_d[write_reg_mul] = write_data_mul;
    end
    if (aluWrite) begin
      regs_d[write_reg] = write_data;
    end
  end

  // Register array storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with same-cycle bypass, using the same ALU-over-MUL priority
  // as the array update so a bypassed value always matches what will be
  // stored. Index 0 short-circuits to zero ahead of any bypass.
  always_comb begin
    read_data_a = regs_q[read_reg_a];
    if (read_reg_a == ZERO_ID) begin
      read_data_a = '0;
    end else if (write_enable && (write_reg == read_reg_a)) begin
      read_data_a = write_data;
    end else if (write_enable_mul && (write_reg_mul == read_reg_a)) begin
      read_data_a = write_data_mul;
    end

    read_data_b = regs_q[read_reg_b];
    if (read_reg_b == ZERO_ID) begin
      read_data_b = '0;
    end else if (write_enable && (write_reg == read_reg_b)) begin
      read_data_b = write_data;
    end else if (write_enable_mul && (write_reg_mul == read_reg_b)) begin
      read_data_b = write_data_mul;
    end
  end

  cpu_mul_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .REG_ID_WIDTH (REG_ID_WIDTH),
    .CNT_WIDTH    ($clog2(NUM_REGS) + 1)
  ) u_scoreboard (
    .clock              (clock),
    .reset              (reset),
    .mul_issue_i        (mul_issue),
    .mul_issue_reg_i    (mul_issue_reg),
    .write_enable_mul_i (write_enable_mul),
    .write_reg_mul_i    (write_reg_mul),
    .read_reg_a_i       (read_reg_a),
    .read_reg_b_i       (read_reg_b),
    .busy_a_o           (busy_a),
    .busy_b_o           (busy_b),
    .mul_pending_o      (mul_pending),
    .waw_error_o        (waw_error)
  );

endmodule : cpu_bank_reg

// File: tb/tb_cpu_bank_reg.sv
// Self-checking bench for cpu_bank_reg: directed scenarios followed by
// randomized traffic compared against a behavioural model of the bank.
module tb_cpu_bank_reg;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg_a, read_reg_b;
  logic [31:0] read_data_a, read_data_b;
  logic        busy_a, busy_b;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable_mul;
  logic [4:0]  write_reg_mul;
  logic [31:0] write_data_mul;
  logic        mul_issue;
  logic [4:0]  mul_issue_reg;
  logic [5:0]  mul_pending;
  logic        waw_error;

  int assertCount = 0;
  int failCount   = 0;

  // Behavioural model: plain array of values, array of busy flags, sticky flag.
  logic [31:0] mRegs [32];
  bit          mBusy [32];
  bit          mWaw;
  bit          modelValid = 0;

  cpu_bank_reg dut (
    .clock            (clock),
    .reset            (reset),
    .read_reg_a       (read_reg_a),
    .read_reg_b       (read_reg_b),
    .read_data_a      (read_data_a),
    .read_data_b      (read_data_b),
    .busy_a           (busy_a),
    .busy_b           (busy_b),
    .write_enable     (write_enable),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .write_enable_mul (write_enable_mul),
    .write_reg_mul    (write_reg_mul),
    .write_data_mul   (write_data_mul),
    .mul_issue        (mul_issue),
    .mul_issue_reg    (mul_issue_reg),
    .mul_pending      (mul_pending),
    .waw_error        (waw_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs are driven right after a falling edge, then settle for 1 time unit.
  task automatic applyStimulus(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                               input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic wem, input logic [4:0] wrm, input logic [31:0] wdm,
                               input logic mi, input logic [4:0] mir);
    reset = rst;
    read_reg_a = ra;           read_reg_b = rb;
    write_enable = we;         write_reg = wr;         write_data = wd;
    write_enable_mul = wem;    write_reg_mul = wrm;    write_data_mul = wdm;
    mul_issue = mi;            mul_issue_reg = mir;
    #1;
  endtask

  task automatic idleCycleInputs(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(1'b0, ra, rb, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (write_enable && write_reg == idx) return write_data;
    if (write_enable_mul && write_reg_mul == idx) return write_data_mul;
    return mRegs[idx];
  endfunction

  function automatic logic modelBusy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    return mBusy[idx] && !(write_enable_mul && write_reg_mul == idx);
  endfunction

  function automatic logic [31:0] modelPending();
    int n = 0;
    for (int i = 0; i < 32; i++) if (mBusy[i]) n++;
    return 32'(n);
  endfunction

  task automatic modelUpdate();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mRegs[i] = 32'd0;
        mBusy[i] = 1'b0;
      end
      mWaw = 1'b0;
      modelValid = 1;
    end else begin
      if (mul_issue && mul_issue_reg != 0 && mBusy[mul_issue_reg] &&
          !(write_enable_mul && write_reg_mul == mul_issue_reg))
        mWaw = 1'b1;
      if (write_enable_mul && write_reg_mul != 0) begin
        mRegs[write_reg_mul] = write_data_mul;
        mBusy[write_reg_mul] = 1'b0;
      end
      if (write_enable && write_reg != 0) mRegs[write_reg] = write_data;
      if (mul_issue && mul_issue_reg != 0) mBusy[mul_issue_reg] = 1'b1;
    end
  endtask

  // Compare every output against the model, clock once, advance the model.
  task automatic runCycle();
    if (modelValid) begin
      checkOutput("read_data_a", read_data_a, modelRead(read_reg_a));
      checkOutput("read_data_b", read_data_b, modelRead(read_reg_b));
      checkOutput("busy_a", {31'd0, busy_a}, {31'd0, modelBusy(read_reg_a)});
      checkOutput("busy_b", {31'd0, busy_b}, {31'd0, modelBusy(read_reg_b)});
      checkOutput("mul_pending", {26'd0, mul_pending}, modelPending());
      checkOutput("waw_error", {31'd0, waw_error}, {31'd0, mWaw});
    end
    @(posedge clock);
    modelUpdate();
    @(negedge clock);
  endtask

  function automatic logic [4:0] pickReg();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    @(negedge clock);

    // Reset cycle; model becomes valid after the edge.
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b1, 5'd3, 32'hAAAA_5555, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7);
    runCycle();
    idleCycleInputs(5'd3, 5'd7);
    checkOutput("reset_data_a", read_data_a, 32'd0);
    checkOutput("reset_pending", {26'd0, mul_pending}, 32'd0);
    checkOutput("reset_busy_b", {31'd0, busy_b}, 32'd0);
    runCycle();

    // ALU write with same-cycle bypass, then from the array.
    applyStimulus(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("bypass_alu", read_data_a, 32'hDEAD_BEEF);
    runCycle();
    idleCycleInputs(5'd3, 5'd0);
    checkOutput("array_alu", read_data_a, 32'hDEAD_BEEF);
    runCycle();

    // Both ports write reg 7: ALU wins.
    applyStimulus(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0);
    checkOutput("both_bypass", read_data_a, 32'h11);
    runCycle();
    idleCycleInputs(5'd7, 5'd0);
    checkOutput("both_array", read_data_a, 32'h11);
    runCycle();

    // Writes to register 0 ignored.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0);
    checkOutput("zero_bypass", read_data_a, 32'd0);
    runCycle();
    idleCycleInputs(5'd0, 5'd0);
    checkOutput("zero_array", read_data_a, 32'd0);
    runCycle();

    // Multiply lifecycle on reg 5.
    applyStimulus(1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    checkOutput("issue_no_same_cycle_busy", {31'd0, busy_b}, 32'd0);
    runCycle();
    idleCycleInputs(5'd0, 5'd5);
    checkOutput("mul_busy_set", {31'd0, busy_b}, 32'd1);
    checkOutput("mul_pending_1", {26'd0, mul_pending}, 32'd1);
    runCycle();
    applyStimulus(1'b0, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    checkOutput("complete_busy", {31'd0, busy_b}, 32'd0);
    checkOutput("complete_bypass", read_data_b, 32'h1234);
    runCycle();
    idleCycleInputs(5'd0, 5'd5);
    checkOutput("complete_pending", {26'd0, mul_pending}, 32'd0);
    checkOutput("complete_array", read_data_b, 32'h1234);
    runCycle();

    // Same-cycle set and clear of reg 9.
    applyStimulus(1'b0, 5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    runCycle();
    applyStimulus(1'b0, 5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    runCycle();
    idleCycleInputs(5'd0, 5'd9);
    checkOutput("setclr_busy", {31'd0, busy_b}, 32'd1);
    checkOutput("setclr_pending", {26'd0, mul_pending}, 32'd1);
    checkOutput("setclr_waw", {31'd0, waw_error}, 32'd0);
    runCycle();

    // Double issue to reg 4 raises WAW; reset clears everything.
    applyStimulus(1'b0, 5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    runCycle();
    applyStimulus(1'b0, 5'd4, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    runCycle();
    idleCycleInputs(5'd4, 5'd9);
    checkOutput("waw_set", {31'd0, waw_error}, 32'd1);
    checkOutput("waw_pending", {26'd0, mul_pending}, 32'd2);
    runCycle();
    applyStimulus(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    runCycle();
    idleCycleInputs(5'd3, 5'd7);
    checkOutput("post_reset_waw", {31'd0, waw_error}, 32'd0);
    checkOutput("post_reset_pending", {26'd0, mul_pending}, 32'd0);
    checkOutput("post_reset_a", read_data_a, 32'd0);
    checkOutput("post_reset_b", read_data_b, 32'd0);
    runCycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                    pickReg(), pickReg(),
                    ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, pickReg(), $urandom,
                    ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, pickReg(), $urandom,
                    ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0, pickReg());
      runCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_cpu_bank_reg
